// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared definitions for the 5-stage pipeline front end.
//            Operand-source select codes, next-PC select codes, the
//            canonical NOP word, and the operand-select decode function
//            used for both the rs and rt operands.
// Ports    : (package, no ports)
// Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

    // Operand source select codes consumed by the D/E register
    localparam logic [1:0] FWD_RF   = 2'b00;  // register file
    localparam logic [1:0] FWD_EALU = 2'b01;  // EXE-stage ALU result
    localparam logic [1:0] FWD_MALU = 2'b10;  // MEM-stage ALU result
    localparam logic [1:0] FWD_MMEM = 2'b11;  // MEM-stage load data

    // Next-PC select codes from decode
    localparam logic [1:0] PCSRC_PC4 = 2'b00;  // sequential
    localparam logic [1:0] PCSRC_BR  = 2'b01;  // branch target
    localparam logic [1:0] PCSRC_JR  = 2'b10;  // register-indirect jump
    localparam logic [1:0] PCSRC_J   = 2'b11;  // absolute jump

    // All-zero word is sll $0,$0,0: harmless, writes $0
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Operand source for one source register. The EXE check comes first so
    // the youngest producer wins when EXE and MEM target the same register.
    // Register $0 never forwards since it is hardwired to zero.
    function automatic logic [1:0] fwd_sel(
        input logic       ewreg,
        input logic       em2reg,
        input logic [4:0] ern,
        input logic       mwreg,
        input logic       mm2reg,
        input logic [4:0] mrn,
        input logic [4:0] src
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (ewreg && !em2reg && (ern != 5'd0) && (ern == src)) begin
            sel = FWD_EALU;
        end else if (mwreg && !mm2reg && (mrn != 5'd0) && (mrn == src)) begin
            sel = FWD_MALU;
        end else if (mwreg && mm2reg && (mrn != 5'd0) && (mrn == src)) begin
            sel = FWD_MMEM;
        end
        return sel;
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_pc_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pc_reg
// Purpose  : Program counter register with write enable. Loads RESET_PC
//            asynchronously while clrn is low; otherwise captures d on the
//            rising clock edge whenever en is high.
// Ports    : clk   - clock
//            clrn  - asynchronous active-low reset
//            en    - load enable (low holds the current PC)
//            d     - next PC
//            q     - current PC
// Revision : 1.0  initial release
// ============================================================================
module pipe_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    logic [31:0] r_pc;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_pc <= RESET_PC;
        end else if (en) begin
            r_pc <= d;
        end
    end

    assign q = r_pc;

endmodule : pipe_pc_reg
`default_nettype wire

// File: rtl/pipe_ifid_hazard.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ifid_hazard
// Purpose  : Fetch/decode front end of the 5-stage pipeline. Holds the PC
//            and the IF/ID latch, selects the next PC, produces the operand
//            source selects and the load-use interlock for the D/E register,
//            and counts stall cycles for performance debug.
// Ports    : clk, clrn                    - clock, async active-low reset
//            ins                          - fetched instruction at pc
//            pcsource, bpc, ra_pc, jpc    - next-PC select and targets
//            dusers, dusert               - decoded instruction reads rs/rt
//            ewreg, em2reg, ern           - EXE-stage writeback info
//            mwreg, mm2reg, mrn           - MEM-stage writeback info
//            pc                           - current fetch PC
//            dinst, dpc4, dvalid          - IF/ID latch contents
//            dADEPEEN, dBDEPEEN           - operand A/B source selects
//            wpcir                        - PC/IF-ID write enable (0 = stall)
//            dbubble                      - D/E must capture a NOP
//            stall_cnt                    - saturating stall-cycle count
// Revision : 1.0  initial release
// ============================================================================
module pipe_ifid_hazard
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DELAY_SLOT = 1,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [31:0]      ins,
    input  logic [1:0]       pcsource,
    input  logic [31:0]      bpc,
    input  logic [31:0]      ra_pc,
    input  logic [31:0]      jpc,
    input  logic             dusers,
    input  logic             dusert,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       ern,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [4:0]       mrn,
    output logic [31:0]      pc,
    output logic [31:0]      dinst,
    output logic [31:0]      dpc4,
    output logic             dvalid,
    output logic [1:0]       dADEPEEN,
    output logic [1:0]       dBDEPEEN,
    output logic             wpcir,
    output logic             dbubble,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic             c_flush_on_redirect = (DELAY_SLOT == 0);

    logic [31:0]      w_pc;
    logic [31:0]      w_pc4;
    logic [31:0]      w_npc;
    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic             w_stall;
    logic             w_flush;

    logic [31:0]      r_dinst;
    logic [31:0]      r_dpc4;
    logic             r_dvalid;
    logic [CNT_W-1:0] r_stall_cnt;

    // ------------------------------------------------------------------
    // Decode register fields from the IF/ID instruction
    // ------------------------------------------------------------------
    assign w_rs = r_dinst[25:21];
    assign w_rt = r_dinst[20:16];

    // ------------------------------------------------------------------
    // Operand source selects
    // ------------------------------------------------------------------
    assign dADEPEEN = fwd_sel(ewreg, em2reg, ern, mwreg, mm2reg, mrn, w_rs);
    assign dBDEPEEN = fwd_sel(ewreg, em2reg, ern, mwreg, mm2reg, mrn, w_rt);

    // ------------------------------------------------------------------
    // Load-use interlock. A load in EXE has no data yet, so a dependent
    // instruction in decode must wait one cycle; after that the load sits
    // in MEM and the FWD_MMEM path covers it.
    // ------------------------------------------------------------------
    assign w_stall = ewreg && em2reg && (ern != 5'd0) &&
                     ((dusers && (ern == w_rs)) || (dusert && (ern == w_rt)));

    assign wpcir   = ~w_stall;
    assign dbubble = w_stall | ~r_dvalid;

    // ------------------------------------------------------------------
    // Next PC. The adder wraps naturally at 32 bits.
    // ------------------------------------------------------------------
    assign w_pc4 = w_pc + 32'd4;

    always_comb begin
        w_npc = w_pc4;
        case (pcsource)
            PCSRC_PC4: w_npc = w_pc4;
            PCSRC_BR:  w_npc = bpc;
            PCSRC_JR:  w_npc = ra_pc;
            PCSRC_J:   w_npc = jpc;
            default:   w_npc = w_pc4;
        endcase
    end

    // Without a delay slot the instruction fetched alongside a redirect is
    // on the wrong path and is discarded.
    assign w_flush = c_flush_on_redirect && (pcsource != PCSRC_PC4);

    pipe_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .clrn (clrn),
        .en   (wpcir),
        .d    (w_npc),
        .q    (w_pc)
    );

    assign pc = w_pc;

    // ------------------------------------------------------------------
    // IF/ID latch. Holds on a stall so a redirect that coincides with a
    // stall is re-evaluated next cycle against the forwarded operands.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_dinst  <= NOP;
            r_dpc4   <= 32'h0000_0000;
            r_dvalid <= 1'b0;
        end else if (wpcir) begin
            r_dpc4 <= w_pc4;
            if (w_flush) begin
                r_dinst  <= NOP;
                r_dvalid <= 1'b0;
            end else begin
                r_dinst  <= ins;
                r_dvalid <= 1'b1;
            end
        end
    end

    assign dinst  = r_dinst;
    assign dpc4   = r_dpc4;
    assign dvalid = r_dvalid;

    // ------------------------------------------------------------------
    // Saturating stall counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule : pipe_ifid_hazard
`default_nettype wire

// File: doc/pipe_ifid_hazard.md
Name: pipe_ifid_hazard

Overview:
- Fetch/decode front end of the 5-stage pipeline, directly upstream of the D/E pipeline register.
- Holds the PC register and the IF/ID latch, and selects the next PC.
- Generates the 2-bit operand-source selects dADEPEEN/dBDEPEEN and the load-use interlock that the D/E register consumes.
- Also counts stall cycles for performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DELAY_SLOT, 1, 1 = taken branch/jump does not flush IF/ID (MIPS delay slot); 0 = flush IF/ID on redirect
CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  clock, all state updates on posedge
clrn  in  1  asynchronous active-low reset
ins  in  32  instruction word from instruction memory at pc
pcsource  in  2  next-PC select from decode: 00 pc+4, 01 bpc, 10 ra_pc, 11 jpc
bpc  in  32  branch target
ra_pc  in  32  jr target (forwarded register value)
jpc  in  32  jump target
dusers  in  1  decoded instruction reads rs
dusert  in  1  decoded instruction reads rt
ewreg  in  1  EXE stage writes register file
em2reg  in  1  EXE stage is a load
ern  in  5  EXE destination register
mwreg  in  1  MEM stage writes register file
mm2reg  in  1  MEM stage is a load
mrn  in  5  MEM destination register
pc  out  32  current fetch PC
dinst  out  32  IF/ID instruction
dpc4  out  32  IF/ID pc+4
dvalid  out  1  IF/ID holds a real (non-flushed) instruction
dADEPEEN  out  2  source select for operand A (rs)
dBDEPEEN  out  2  source select for operand B (rt)
wpcir  out  1  1 = PC and IF/ID update this cycle; 0 = stall
dbubble  out  1  1 = D/E must capture a NOP (wreg/wmem forced 0)
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (clrn=0, asynchronous): pc=RESET_PC, dinst=0, dpc4=0, dvalid=0, stall_cnt=0.
- Combinational outputs during reset follow their equations with dinst=0: rs=rt=0, so selects are 00 and wpcir=1.
- Register fields are decoded from dinst: rs=dinst[25:21], rt=dinst[20:16].
- Operand A select (rs; B is identical with rt). First match wins:
  - 01 if ewreg & ~em2reg & ern!=0 & ern==rs (EXE ALU result)
  - 10 if mwreg & ~mm2reg & mrn!=0 & mrn==rs (MEM ALU result)
  - 11 if mwreg & mm2reg & mrn!=0 & mrn==rs (MEM load data)
  - else 00 (register file)
- EXE match has priority over MEM, so the newest value wins.
- Load-use stall: stall = ewreg & em2reg & ern!=0 & ((dusers & ern==rs) | (dusert & ern==rt)).
  - wpcir = ~stall; dbubble = stall | ~dvalid.
- pc+4 is computed internally, 32-bit wrapping (32'hFFFF_FFFC + 4 = 0).
- Next PC mux by pcsource; pc updates on posedge only when wpcir=1.
- IF/ID update when wpcir=1:
  - Normal: dinst<=ins, dpc4<=pc+4, dvalid<=1.
  - Flush (DELAY_SLOT=0 and pcsource!=00): dinst<=0, dvalid<=0, dpc4<=pc+4.
- Stall and redirect in the same cycle: stall wins. PC and IF/ID hold, and the redirect is re-evaluated next cycle with correct operands.
- A stall lasts exactly 1 cycle per load-use, since the load moves to MEM and the select becomes 11.
- stall_cnt increments on each stall cycle and saturates at all-ones.
- Reset mid-stall clears all state immediately; the first post-reset fetch is RESET_PC.

Decomposition:
- Shared package pipe_pkg: forwarding codes FWD_RF=2'b00, FWD_EALU=2'b01, FWD_MALU=2'b10, FWD_MMEM=2'b11.
- Also in pipe_pkg: PCSRC_* encodings and NOP=32'h0.
- One sub-module, pipe_pc_reg: enable-gated PC register with async reset to RESET_PC.

Test Plan:
- Reset release, pcsource=00, wpcir=1 -> pc sequence 0,4,8,C; dinst lags ins by one cycle; dvalid=1 from the 2nd cycle.
- `lw $5`, then `add $6,$5,$7` reads rs=5 (ewreg=1, em2reg=1, ern=5, dusers=1) -> wpcir=0 and dbubble=1 for 1 cycle, pc held, stall_cnt=1. The next cycle dADEPEEN=11.
- ern=8 ALU and mrn=8 ALU both writing, rs=8 -> dADEPEEN=01; with ern=0 writing and rs=0 -> 00.
- DELAY_SLOT=0, pcsource=01, bpc=32'h40 -> next pc=0x40, dinst=0, dvalid=0, dbubble=1. DELAY_SLOT=1, same stimulus -> dinst=delay-slot ins.
- Stall and pcsource=11 in the same cycle -> pc unchanged; redirect to jpc happens the following cycle.
- clrn pulled low mid-stall -> pc=RESET_PC and dinst=0 asynchronously; 2^CNT_W+5 stalls -> stall_cnt stays all-ones.
